// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern and overlap mode; registered match pulse.
// Optional saturating match counter (match_cnt/cnt_clr) enabled by defining SEQ_MATCH_CNT_EN.
module seq_detector_param #(
    parameter int                PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
    parameter logic              OVERLAP = 1'b1,
    parameter int                CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din_valid,
    input  logic             din,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    output logic             match,
    output logic             busy,
`ifdef SEQ_MATCH_CNT_EN
    output logic             cfg_err,
    output logic [CNT_W-1:0] match_cnt,
    input  logic             cnt_clr
`else
    output logic             cfg_err
`endif
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {IDLE, FILL, DETECT} state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   shift_q, shift_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic               ovl_q, ovl_d;
    logic               match_q, match_d;
    logic               cfg_err_q, cfg_err_d;
    logic [PAT_W-1:0]   window;
    logic               full;

    // The incoming bit completes a full window once PAT_W-1 bits are already held.
    assign window = {shift_q[PAT_W-2:0], din};
    assign full   = (fill_q >= FILL_W'(PAT_W - 1));

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        ovl_d     = ovl_q;
        match_d   = 1'b0;
        cfg_err_d = 1'b0;

        if (cfg_we) begin
            if (state_q == IDLE) begin
                pat_d = cfg_pattern;
                ovl_d = cfg_overlap;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FILL;
                    shift_d = '0;
                    fill_d  = '0;
                end
                FILL, DETECT: begin
                    if (din_valid) begin
                        shift_d = window;
                        if (!full) fill_d = fill_q + FILL_W'(1);
                        if (full) state_d = DETECT;
                        if (full && (window == pat_q)) begin
                            match_d = 1'b1;
                            // Non-overlapping: the matched bits may not seed the next window.
                            if (!ovl_q) begin
                                shift_d = '0;
                                fill_d  = '0;
                                state_d = FILL;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            fill_q    <= '0;
            pat_q     <= PATTERN;
            ovl_q     <= OVERLAP;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            ovl_q     <= ovl_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign match   = match_q;
    assign busy    = (state_q != IDLE);
    assign cfg_err = cfg_err_q;

`ifdef SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts visible match pulses; clear takes priority over a coincident pulse.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (match_q && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: expected match per driven cycle is queued and
// compared one edge later. Counter checks run only when SEQ_MATCH_CNT_EN is defined.
module tb_seq_detector_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             din_valid = 1'b0;
    logic             din = 1'b0;
    logic             cfg_we = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic             cfg_overlap = 1'b1;
    logic             cnt_clr = 1'b0;
    logic             match, busy, cfg_err;
    logic [CNT_W-1:0] match_cnt;

    int    checks = 0;
    int    failures = 0;
    string tname = "reset";
    logic  exp_q[$];

    always #5 clk = ~clk;

    seq_detector_param #(
        .PAT_W(PAT_W), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .din_valid(din_valid), .din(din),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
        .match(match), .busy(busy),
`ifdef SEQ_MATCH_CNT_EN
        .cfg_err(cfg_err), .match_cnt(match_cnt), .cnt_clr(cnt_clr)
`else
        .cfg_err(cfg_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s/%s got=%0h exp=%0h", tname, tag, got, exp);
        end
    endtask

    // One clock: drive inputs, queue the expected match, compare after the edge.
    task automatic cyc(input logic e, input logic v, input logic d, input logic w, input logic ex);
        logic exp_m;
        en = e; din_valid = v; din = d; cfg_we = w;
        exp_q.push_back(ex);
        @(posedge clk); #1;
        exp_m = exp_q.pop_front();
        chk("match", {31'b0, match}, {31'b0, exp_m});
        cfg_we = 1'b0;
    endtask

    // Send n bits MSB first with per-bit expected match in ex (same bit order).
    task automatic send(input logic [31:0] s, input logic [31:0] ex, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, 1'b1, s[i], 1'b0, ex[i]);
    endtask

    initial begin
        rst = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("busy", {31'b0, busy}, 32'd0);
        chk("cfg_err", {31'b0, cfg_err}, 32'd0);
`ifdef SEQ_MATCH_CNT_EN
        chk("cnt_rst", {30'b0, match_cnt}, 32'd0);
`endif
        rst = 1'b1;

        tname = "t1_basic";
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("busy", {31'b0, busy}, 32'd1);
        send(32'b1011, 32'b0001, 4);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("busy_off", {31'b0, busy}, 32'd0);

        tname = "t2_ovl";
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(32'b1011011, 32'b0001001, 7);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tname = "t2_novl";
        cfg_pattern = 4'b1011; cfg_overlap = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("cfg_err", {31'b0, cfg_err}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(32'b1011011, 32'b0001000, 7);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(32'b10111011, 32'b00010001, 8);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cfg_overlap = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        tname = "t3_gap";
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(32'b10, 32'b00, 2);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("busy", {31'b0, busy}, 32'd1);
        send(32'b11, 32'b01, 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        tname = "t4_endrop";
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(32'b101, 32'b000, 3);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(32'b1011, 32'b0001, 4);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        tname = "t5_cfg";
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cfg_pattern = 4'b0110;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("cfg_err_busy", {31'b0, cfg_err}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("cfg_err_pulse", {31'b0, cfg_err}, 32'd0);
        send(32'b1011, 32'b0001, 4);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("cfg_err_idle", {31'b0, cfg_err}, 32'd0);
        send(32'b0110, 32'b0001, 4);
        send(32'b1011, 32'b0000, 4);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cfg_pattern = 4'b1011;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SEQ_MATCH_CNT_EN
        tname = "t6_cnt";
        cnt_clr = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt_clr = 1'b0;
        chk("cnt_clr", {30'b0, match_cnt}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(32'b1011011011011, 32'b0001001001001, 13);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("cnt_sat", {30'b0, match_cnt}, 32'd3);
        send(32'b011, 32'b001, 3);
        cnt_clr = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt_clr = 1'b0;
        chk("cnt_clr_win", {30'b0, match_cnt}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        tname = "t7_rst_override";
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(32'b101, 32'b000, 3);
        rst = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("busy", {31'b0, busy}, 32'd0);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
